// File: rtl/frame_builder.sv
// frame_builder: transmit-side framer in the 80 MHz link domain.
// Each accepted 32-bit word goes out MSB first as a 48-bit frame:
// SYNC_BYTE, then 32 data bits, then the CRC-8 of the data bits.
// The bits use a valid/ready stream handshake.
// Optional macro FRAME_BUILDER_PREFETCH_EN adds a one-word holding register.
// With it, frames can run back to back with no idle cycle between them.
module frame_builder #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter logic [7:0] CRC_POLY   = 8'h07,
  parameter logic [7:0] CRC_INIT   = 8'h00,
  parameter int         FRAME_BITS = 48
) (
  input  logic        clk_link,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        busy,
  output logic [7:0]  frame_count
);

  // The counters and shift registers below are sized for a 48-bit frame only.
  generate
    if (FRAME_BITS != 48) begin : g_frame_bits_check
      $error("frame_builder: FRAME_BITS must be 48");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_CRC} state_t;

  state_t      state_reg;
  logic [31:0] data_sh_reg;      // data word, shifted left as bits leave
  logic [7:0]  byte_sh_reg;      // sync byte or CRC byte, shifted left
  logic [7:0]  crc_reg;
  logic [4:0]  bit_cnt_reg;      // bit index within the current field
  logic        ready_en_reg;     // keeps data_ready low while reset is applied
  logic        bit_out_reg;
  logic        bit_valid_reg;
  logic        busy_reg;
  logic [7:0]  frame_count_reg;

  logic        xfer;
  logic        last_bit;
  logic        accept;
  logic        start_idle;
  logic        start_chain;
  logic        start_frame;
  logic [31:0] start_word;
  logic [7:0]  crc_next;

  // One serial CRC-8 step (non-reflected, MSB first).
  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  assign xfer     = bit_valid_reg & bit_ready;
  assign last_bit = (state_reg == ST_CRC) && (bit_cnt_reg == 5'd7) && xfer;
  assign crc_next = crc_step(crc_reg, bit_out_reg);

`ifdef FRAME_BUILDER_PREFETCH_EN
  logic        hold_full_reg;
  logic [31:0] hold_data_reg;

  assign data_ready  = enable & ready_en_reg & ~hold_full_reg;
  assign accept      = data_valid & data_ready;
  // A held word always goes before a word offered directly.
  assign start_idle  = (state_reg == ST_IDLE) & (hold_full_reg | accept);
  assign start_chain = last_bit & hold_full_reg;
  assign start_word  = hold_full_reg ? hold_data_reg : data_in;

  // Holding register: filled by a word accepted mid-frame, drained at frame start.
  always_ff @(posedge clk_link or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= 32'h0;
    end else if (hold_full_reg && (start_idle || start_chain)) begin
      hold_full_reg <= 1'b0;
    end else if (accept && (state_reg != ST_IDLE)) begin
      hold_full_reg <= 1'b1;
      hold_data_reg <= data_in;
    end
  end
`else
  assign data_ready  = enable & ready_en_reg & (state_reg == ST_IDLE);
  assign accept      = data_valid & data_ready;
  assign start_idle  = accept;
  assign start_chain = 1'b0;
  assign start_word  = data_in;
`endif

  assign start_frame = start_idle | start_chain;

  // Framing FSM: loads a word, then walks through the sync, data and CRC fields.
  always_ff @(posedge clk_link or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      data_sh_reg     <= 32'h0;
      byte_sh_reg     <= 8'h00;
      crc_reg         <= 8'h00;
      bit_cnt_reg     <= 5'd0;
      ready_en_reg    <= 1'b0;
      bit_out_reg     <= 1'b0;
      bit_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      frame_count_reg <= 8'h00;
    end else begin
      ready_en_reg <= 1'b1;
      if (last_bit) begin
        frame_count_reg <= frame_count_reg + 8'd1;
      end
      if (start_frame) begin
        data_sh_reg   <= start_word;
        byte_sh_reg   <= {SYNC_BYTE[6:0], 1'b0};
        crc_reg       <= CRC_INIT;
        bit_cnt_reg   <= 5'd0;
        bit_out_reg   <= SYNC_BYTE[7];
        bit_valid_reg <= 1'b1;
        busy_reg      <= 1'b1;
        state_reg     <= ST_SYNC;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            bit_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
          ST_SYNC: begin
            if (xfer) begin
              if (bit_cnt_reg == 5'd7) begin
                bit_cnt_reg <= 5'd0;
                bit_out_reg <= data_sh_reg[31];
                state_reg   <= ST_DATA;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                bit_out_reg <= byte_sh_reg[7];
                byte_sh_reg <= {byte_sh_reg[6:0], 1'b0};
              end
            end
          end
          ST_DATA: begin
            if (xfer) begin
              crc_reg     <= crc_next;
              data_sh_reg <= {data_sh_reg[30:0], 1'b0};
              if (bit_cnt_reg == 5'd31) begin
                bit_cnt_reg <= 5'd0;
                bit_out_reg <= crc_next[7];
                byte_sh_reg <= {crc_next[6:0], 1'b0};
                state_reg   <= ST_CRC;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                bit_out_reg <= data_sh_reg[30];
              end
            end
          end
          ST_CRC: begin
            if (xfer) begin
              if (bit_cnt_reg == 5'd7) begin
                bit_cnt_reg   <= 5'd0;
                bit_out_reg   <= 1'b0;
                bit_valid_reg <= 1'b0;
                busy_reg      <= 1'b0;
                state_reg     <= ST_IDLE;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                bit_out_reg <= byte_sh_reg[7];
                byte_sh_reg <= {byte_sh_reg[6:0], 1'b0};
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bit_out     = bit_out_reg;
  assign bit_valid   = bit_valid_reg;
  assign busy        = busy_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_frame_builder.sv
// Testbench for frame_builder.
// The reference model builds each expected frame from the word.
// The CRC is computed as polynomial division of data*x^8 by x^8+x^2+x+1.
module tb_frame_builder;

  logic        clk_link = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready = 1'b1;
  logic        busy;
  logic [7:0]  frame_count;

  frame_builder dut (
    .clk_link    (clk_link),
    .rst_n       (rst_n),
    .enable      (enable),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk_link = ~clk_link;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  int   last_xfer_cyc = 0;
  logic rx_q[$];
  bit   rnd_ready = 1'b0;
  logic stall_prev = 1'b0;
  logic bit_prev = 1'b0;

`ifdef FRAME_BUILDER_PREFETCH_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  function automatic logic [7:0] ref_crc(input logic [31:0] d);
    logic [39:0] v;
    v = {d, 8'h00};
    for (int i = 39; i >= 8; i--) begin
      if (v[i]) v = v ^ (40'h107 << (i - 8));
    end
    return v[7:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [31:0] d);
    return {8'hA5, d, ref_crc(d)};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive bit_ready at the falling edge, then sample and record transfers.
  task automatic tick();
    @(negedge clk_link);
    if (rnd_ready) bit_ready = 1'($urandom_range(0, 1));
    #1;
    cyc++;
    if (rst_n && stall_prev) begin
      chk1("stall_valid_held", bit_valid, 1'b1);
      chk1("stall_bit_held", bit_out, bit_prev);
    end
    if (rst_n && bit_valid && bit_ready) begin
      rx_q.push_back(bit_out);
      last_xfer_cyc = cyc;
    end
    stall_prev = rst_n & bit_valid & ~bit_ready;
    bit_prev   = bit_out;
  endtask

  task automatic send(input logic [31:0] w);
    int k;
    #1;
    data_in    = w;
    data_valid = 1'b1;
    k = 0;
    while (!data_ready && k < 200) begin
      tick();
      k++;
    end
    chk1("accept_ready", data_ready, 1'b1);
    tick();
    data_valid = 1'b0;
    data_in    = $urandom;
    first_cyc  = cyc;
  endtask

  task automatic wait_bits(input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 5000) begin
      tick();
      k++;
    end
    chki("bits_received", (rx_q.size() >= n) ? n : rx_q.size(), n);
  endtask

  task automatic get_frame(output logic [47:0] f);
    f = 48'h0;
    for (int i = 0; i < 48; i++) begin
      if (rx_q.size() > 0) f = {f[46:0], rx_q.pop_front()};
      else f = {f[46:0], 1'bx};
    end
  endtask

  logic [47:0] f;
  logic [31:0] w;
  logic [31:0] wq[256];
  logic        acc;
  int          idx;
  int          k;
  int          first;

  initial begin
    // Reset state, with enable already high
    rst_n = 1'b0; enable = 1'b1; bit_ready = 1'b1;
    repeat (3) tick();
    chk1("rst_data_ready", data_ready, 1'b0);
    chk1("rst_bit_valid", bit_valid, 1'b0);
    chk1("rst_bit_out", bit_out, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_frame_count", frame_count, 8'h00);
    rst_n = 1'b1;
    tick();
    chk1("idle_data_ready", data_ready, 1'b1);

    // Single known word, bit_ready held high
    rx_q.delete();
    send(32'h12345678);
    chk1("t1_latency_valid", bit_valid, 1'b1);
    chk1("t1_first_bit", bit_out, 1'b1);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_not_ready", data_ready, 1'b0);
    wait_bits(48);
    chki("t1_contiguous", cyc - first_cyc + 1, 48);
    get_frame(f);
    chk48("t1_frame_model", f, ref_frame(32'h12345678));
    chk48("t1_frame_const", f, 48'hA5_12345678_1C);
    tick();
    chk1("t1_valid_after", bit_valid, 1'b0);
    chk1("t1_busy_after", busy, 1'b0);
    chk8("t1_frame_count", frame_count, 8'h01);
    $display("[TB] frame 12345678 -> %h", f);

    // All-zero word: CRC byte is zero
    send(32'h0);
    wait_bits(48);
    get_frame(f);
    chk48("t2_frame_model", f, ref_frame(32'h0));
    chk8("t2_crc_zero", f[7:0], 8'h00);
    tick();
    chk8("t2_frame_count", frame_count, 8'h02);
    $display("[TB] frame 00000000 -> %h", f);

    // Random bit_ready on the known word, then random words
    rnd_ready = 1'b1;
    send(32'h12345678);
    wait_bits(48);
    get_frame(f);
    chk48("t3_frame_stall", f, 48'hA5_12345678_1C);
    $display("[TB] stalled frame 12345678 -> %h", f);
    for (int n = 0; n < 6; n++) begin
      w = $urandom;
      send(w);
      wait_bits(48);
      get_frame(f);
      chk48("t3_frame_random", f, ref_frame(w));
      $display("[TB] stalled frame %h -> %h", w, f);
    end
    rnd_ready = 1'b0;
    bit_ready = 1'b1;
    repeat (2) tick();
    chk8("t3_frame_count", frame_count, 8'h09);

    // 256 back-to-back random words from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rx_q.delete();
    for (int i = 0; i < 256; i++) wq[i] = $urandom;
    idx = 0; k = 0; first = -1;
    data_in = wq[0]; data_valid = 1'b1;
    while ((idx < 256 || rx_q.size() < 256 * 48) && k < 20000) begin
      acc = data_valid & data_ready;
      tick();
      k++;
      if (first < 0 && bit_valid) first = cyc;
      if (acc) begin
        idx++;
        if (idx < 256) data_in = wq[idx];
        else data_valid = 1'b0;
      end
    end
    chki("t4_words_accepted", idx, 256);
    chki("t4_bits_received", rx_q.size(), 256 * 48);
    chki("t4_span", last_xfer_cyc - first + 1, 256 * 48 + 255 * GAP);
    for (int i = 0; i < 256; i++) begin
      get_frame(f);
      chk48("t4_frame", f, ref_frame(wq[i]));
    end
    tick();
    chk8("t4_frame_count_wrap", frame_count, 8'h00);
    chk1("t4_busy_after", busy, 1'b0);
    $display("[TB] back-to-back 256 frames, span %0d cycles", last_xfer_cyc - first + 1);

    // Reset asserted during the CRC field
    rx_q.delete();
    send($urandom);
    wait_bits(43);
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_bit_valid", bit_valid, 1'b0);
    chk1("t6_rst_bit_out", bit_out, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_data_ready", data_ready, 1'b0);
    chk8("t6_rst_frame_count", frame_count, 8'h00);
    tick();
    rst_n = 1'b1;
    rx_q.delete();
    tick();
    w = $urandom;
    send(w);
    wait_bits(48);
    get_frame(f);
    chk48("t6_frame_after_rst", f, ref_frame(w));
    tick();
    chk8("t6_frame_count", frame_count, 8'h01);
    $display("[TB] frame after reset %h -> %h", w, f);

    // enable dropped during data bit 10
    w = $urandom;
    send(w);
    wait_bits(18);
    enable = 1'b0;
    wait_bits(48);
    get_frame(f);
    chk48("t5_frame_enable_drop", f, ref_frame(w));
    tick();
    chk8("t5_frame_count", frame_count, 8'h02);
    data_in = $urandom;
    data_valid = 1'b1;
    repeat (20) tick();
    chk1("t5_no_ready", data_ready, 1'b0);
    chk1("t5_no_busy", busy, 1'b0);
    chk1("t5_no_valid", bit_valid, 1'b0);
    chki("t5_no_bits", rx_q.size(), 0);
    enable = 1'b1;
    w = $urandom;
    send(w);
    wait_bits(48);
    get_frame(f);
    chk48("t5_frame_reenable", f, ref_frame(w));
    tick();
    chk8("t5_frame_count_after", frame_count, 8'h03);
    $display("[TB] frame after re-enable %h -> %h", w, f);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
